pwm_timer_16bits: RTL and testbench

16-bit PWM carrier generator (timer) for the modulator datapath. It produces a sawtooth (up or down) or triangular (up/down) carrier between 0 and a programmable maximum. It also emits a one-cycle sync pulse at carrier minimum and/or maximum, selected by a mask. Downstream comparators consume carrier; sync aligns duty-cycle register updates.

---
 rtl/pwm_timer_16bits.sv | 104 ++++++++++
 tb/tb_pwm_timer_16bits.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_timer_16bits.sv
// 16-bit PWM carrier generator: sawtooth up/down or triangle between 0 and countmax, with a sync pulse at the selected extremes.
// One clk from an enabled edge to the updated carrier/sync; no combinational input-to-output path.
module pwm_timer_16bits (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [15:0] countmax,
    input  logic [15:0] init_carr,
    input  logic [1:0]  count_mode,
    input  logic [2:0]  syncmode,
    output logic [15:0] carrier,
    output logic        sync
);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_UP   = 2'b10;
    localparam logic [1:0] MODE_UPDN = 2'b11;

    logic [15:0] r_carrier;
    logic        r_sync;
    logic        r_dir_up;
    logic        r_init_done;

    logic [15:0] w_next;
    logic        w_dir_up_next;
    logic        w_counting;
    logic        w_sync_next;
    logic        w_unused;

    assign w_unused = syncmode[2];

    always_comb begin
        w_next        = r_carrier;
        w_dir_up_next = r_dir_up;
        if (!r_init_done) begin
            w_next = (init_carr < countmax) ? init_carr : countmax;
        end else begin
            case (count_mode)
                MODE_DOWN: begin
                    w_dir_up_next = 1'b0;
                    if (r_carrier == 16'd0 || r_carrier > countmax)
                        w_next = countmax;
                    else
                        w_next = r_carrier - 16'd1;
                end
                MODE_UP: begin
                    w_dir_up_next = 1'b1;
                    if (r_carrier >= countmax)
                        w_next = 16'd0;
                    else
                        w_next = r_carrier + 16'd1;
                end
                MODE_UPDN: begin
                    // countmax == 0 must pin the carrier at 0 rather than turn around through M-1 or 1
                    if (r_carrier > countmax) begin
                        w_next        = countmax;
                        w_dir_up_next = 1'b0;
                    end else if (countmax == 16'd0) begin
                        w_next = 16'd0;
                    end else if (r_dir_up && r_carrier == countmax) begin
                        w_next        = countmax - 16'd1;
                        w_dir_up_next = 1'b0;
                    end else if (!r_dir_up && r_carrier == 16'd0) begin
                        w_next        = 16'd1;
                        w_dir_up_next = 1'b1;
                    end else if (r_dir_up) begin
                        w_next = r_carrier + 16'd1;
                    end else begin
                        w_next = r_carrier - 16'd1;
                    end
                end
                default: begin
                    w_next = r_carrier;
                end
            endcase
        end
    end

    assign w_counting  = ce && r_init_done && (count_mode != MODE_HOLD);
    assign w_sync_next = w_counting &&
                         (((w_next == 16'd0) && syncmode[0]) ||
                          ((w_next == countmax) && syncmode[1]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_carrier   <= 16'd0;
            r_sync      <= 1'b0;
            r_dir_up    <= 1'b1;
            r_init_done <= 1'b0;
        end else if (ce) begin
            r_carrier   <= w_next;
            r_sync      <= w_sync_next;
            r_dir_up    <= w_dir_up_next;
            r_init_done <= 1'b1;
        end else begin
            r_sync <= 1'b0;
        end
    end

    assign carrier = r_carrier;
    assign sync    = r_sync;

endmodule

// File: tb/tb_pwm_timer_16bits.sv
// Randomized and directed bench for pwm_timer_16bits against a behavioural carrier model.
module tb_pwm_timer_16bits;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [15:0] countmax;
    logic [15:0] init_carr;
    logic [1:0]  count_mode;
    logic [2:0]  syncmode;
    logic [15:0] carrier;
    logic        sync;

    int n_checks = 0;
    int n_errors = 0;

    // model state
    int m_carr;
    bit m_sync;
    bit m_up;
    bit m_loaded;

    pwm_timer_16bits dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .countmax   (countmax),
        .init_carr  (init_carr),
        .count_mode (count_mode),
        .syncmode   (syncmode),
        .carrier    (carrier),
        .sync       (sync)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_carr   = 0;
        m_sync   = 0;
        m_up     = 1;
        m_loaded = 0;
    endtask

    task automatic model_edge();
        int c, mx, nx;
        c  = m_carr;
        mx = int'(countmax);
        nx = c;
        if (rst) begin
            model_reset();
        end else if (!ce) begin
            m_sync = 0;
        end else if (!m_loaded) begin
            m_carr   = (int'(init_carr) < mx) ? int'(init_carr) : mx;
            m_loaded = 1;
            m_sync   = 0;
        end else begin
            case (count_mode)
                2'd1: begin
                    m_up = 0;
                    nx = (c == 0 || c > mx) ? mx : c - 1;
                end
                2'd2: begin
                    m_up = 1;
                    nx = (c >= mx) ? 0 : c + 1;
                end
                2'd3: begin
                    if (c > mx) begin nx = mx; m_up = 0; end
                    else if (mx == 0) nx = 0;
                    else if (m_up && c == mx) begin nx = mx - 1; m_up = 0; end
                    else if (!m_up && c == 0) begin nx = 1; m_up = 1; end
                    else nx = m_up ? c + 1 : c - 1;
                end
                default: nx = c;
            endcase
            m_sync = (count_mode != 2'd0) &&
                     ((nx == 0 && syncmode[0]) || (nx == mx && syncmode[1]));
            m_carr = nx;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("carrier", 32'(carrier), 32'(m_carr));
        chk("sync", 32'(sync), 32'(m_sync));
    endtask

    initial begin
        int pulses;
        int held;
        int maxseen;

        // 1: reset and load
        model_reset();
        rst = 1; ce = 1; init_carr = 16'h0000; countmax = 16'h00FF;
        count_mode = 2'b01; syncmode = 3'b011;
        #2;
        chk("rst_carrier", 32'(carrier), 32'h0);
        chk("rst_sync", 32'(sync), 32'h0);
        step();
        rst = 0;
        step();
        chk("load", 32'(carrier), 32'h0000);
        chk("load_sync", 32'(sync), 32'h0);
        step();
        chk("first_wrap", 32'(carrier), 32'h00FF);
        step();
        chk("first_dec", 32'(carrier), 32'h00FE);

        // 2: down sawtooth, two pulses per 256-cycle period
        pulses = 0;
        for (int i = 0; i < 512; i++) begin
            step();
            pulses += int'(sync);
        end
        chk("down_pulses", 32'(pulses), 32'd4);

        // 3: switch to up/down, period 510
        for (int i = 0; i < 1500; i++) step();
        count_mode = 2'b11;
        pulses = 0;
        for (int i = 0; i < 1020; i++) begin
            step();
            pulses += int'(sync);
            if (sync) chk("updn_sync_at_extreme", 32'(carrier == 16'h0 || carrier == 16'hFF), 32'd1);
        end
        chk("updn_pulses", 32'(pulses), 32'd4);

        // 4: up sawtooth with min-only sync
        count_mode = 2'b10; countmax = 16'h0010; syncmode = 3'b001;
        for (int i = 0; i < 3; i++) step();
        pulses = 0; maxseen = 0;
        for (int i = 0; i < 34; i++) begin
            step();
            pulses += int'(sync);
            if (int'(carrier) > maxseen) maxseen = int'(carrier);
            if (sync) chk("up_sync_at_zero", 32'(carrier), 32'h0);
        end
        chk("up_pulses", 32'(pulses), 32'd2);
        chk("up_max", 32'(maxseen), 32'h10);

        // 5: ce gating, then countmax shrink in up/down
        held = m_carr;
        ce = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("ce_hold", 32'(carrier), 32'(held));
            chk("ce_sync", 32'(sync), 32'h0);
        end
        ce = 1; countmax = 16'h00FF;
        for (int i = 0; i < 300 && m_carr != 16'h80; i++) step();
        chk("reach_80", 32'(carrier), 32'h80);
        count_mode = 2'b11; countmax = 16'h0040;
        step();
        chk("shrink_clamp", 32'(carrier), 32'h40);
        step();
        chk("shrink_down", 32'(carrier), 32'h3F);

        // 6: async reset between edges
        for (int i = 0; i < 7; i++) step();
        #3 rst = 1;
        #1;
        chk("async_carrier", 32'(carrier), 32'h0);
        chk("async_sync", 32'(sync), 32'h0);
        model_reset();
        step();
        rst = 0; init_carr = 16'h0005; countmax = 16'h00FF;
        step();
        chk("reload", 32'(carrier), 32'h5);

        // random phase
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(49) == 0)
                countmax = ($urandom_range(1) != 0) ? 16'($urandom_range(20)) : 16'($urandom);
            if ($urandom_range(19) == 0) count_mode = 2'($urandom);
            if ($urandom_range(19) == 0) syncmode = 3'($urandom);
            init_carr = 16'($urandom);
            ce  = ($urandom_range(7) != 0);
            rst = ($urandom_range(499) == 0);
            step();
        end
        rst = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
